// File: rtl/snow_flake_render.sv
// Snowflake overlay stage for a 640x480 timing generator: draws NUM_FLAKES white squares and moves them once per frame.
// Define SNOW_WIND_EN to add a +/-1 pixel horizontal drift to falling flakes.
module snow_flake_render #(
    parameter int unsigned NUM_FLAKES = 8,
    parameter int unsigned FLAKE_SIZE = 4,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned FALL_STEP  = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [11:0] BG_RGB     = 12'h013,
    parameter logic [11:0] FG_RGB     = 12'hFFF
) (
    input  logic       clk_pix,
    input  logic       rst_pix_n,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       de,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_de
);

    localparam int unsigned IDX_W     = (NUM_FLAKES > 1) ? $clog2(NUM_FLAKES) : 1;
    localparam int unsigned X_MAX     = H_ACTIVE - FLAKE_SIZE;
    localparam int unsigned X_PITCH   = H_ACTIVE / NUM_FLAKES;
    localparam int unsigned Y_PITCH   = V_ACTIVE / NUM_FLAKES;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t                       state;
    state_t                       state_nx;
    logic [IDX_W-1:0]             idx;
    logic [IDX_W-1:0]             idx_nx;
    logic                         upd_c;
    logic                         frame_tick_c;
    logic [15:0]                  lfsr;
    logic [NUM_FLAKES-1:0][9:0]   fx;
    logic [NUM_FLAKES-1:0][9:0]   fy;

    logic [9:0]                   x_sel_c;
    logic [9:0]                   y_sel_c;
    logic [10:0]                  y_sum_c;
    logic [9:0]                   x_spawn_c;
    logic [9:0]                   x_new_c;
    logic [9:0]                   y_new_c;
    logic                         hit_c;

    logic                         hit_d1;
    logic                         de_d1;
    logic                         hs_d1;
    logic                         vs_d1;

    // First blanking line start; flakes only move after this so active video never tears.
    assign frame_tick_c = (sx == 10'd0) && (sy == 10'(V_ACTIVE));

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Walk the flake table one entry per cycle; ticks arriving mid-walk are dropped.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        upd_c    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick_c) begin
                    state_nx = UPDATE;
                    idx_nx   = '0;
                end
            end
            UPDATE: begin
                upd_c = 1'b1;
                if (idx == IDX_W'(NUM_FLAKES - 1)) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + IDX_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Next position of the selected flake; y_sum is one bit wider so the bottom test cannot wrap.
    always_comb begin
        x_sel_c   = fx[idx];
        y_sel_c   = fy[idx];
        y_sum_c   = 11'(y_sel_c) + 11'(FALL_STEP) + 11'(lfsr[0]);
        x_spawn_c = (lfsr[9:0] > 10'(X_MAX)) ? (lfsr[9:0] - 10'd512) : lfsr[9:0];
        x_new_c   = x_sel_c;
        y_new_c   = y_sum_c[9:0];
        if (y_sum_c >= 11'(V_ACTIVE)) begin
            y_new_c = 10'd0;
            x_new_c = x_spawn_c;
        end else begin
`ifdef SNOW_WIND_EN
            if (lfsr[1]) begin
                x_new_c = (x_sel_c >= 10'(X_MAX)) ? 10'(X_MAX) : (x_sel_c + 10'd1);
            end else begin
                x_new_c = (x_sel_c == 10'd0) ? 10'd0 : (x_sel_c - 10'd1);
            end
`else
            x_new_c = x_sel_c;
`endif
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            for (int i = 0; i < NUM_FLAKES; i++) begin
                fx[i] <= 10'(i * X_PITCH);
                fy[i] <= 10'(i * Y_PITCH);
            end
        end else if (upd_c) begin
            fx[idx] <= x_new_c;
            fy[idx] <= y_new_c;
        end
    end

    always_comb begin
        hit_c = 1'b0;
        for (int i = 0; i < NUM_FLAKES; i++) begin
            if ((sx >= fx[i]) && ({1'b0, sx} < (11'(fx[i]) + 11'(FLAKE_SIZE))) &&
                (sy >= fy[i]) && ({1'b0, sy} < (11'(fy[i]) + 11'(FLAKE_SIZE)))) begin
                hit_c = 1'b1;
            end
        end
        hit_c = hit_c & de;
    end

    // Two-stage pixel pipeline; syncs ride alongside so they stay aligned with colour.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            hit_d1    <= 1'b0;
            de_d1     <= 1'b0;
            hs_d1     <= 1'b1;
            vs_d1     <= 1'b1;
            vga_r     <= 4'h0;
            vga_g     <= 4'h0;
            vga_b     <= 4'h0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vga_de    <= 1'b0;
        end else begin
            hit_d1    <= hit_c;
            de_d1     <= de;
            hs_d1     <= hsync;
            vs_d1     <= vsync;
            if (!de_d1) begin
                {vga_r, vga_g, vga_b} <= 12'h000;
            end else if (hit_d1) begin
                {vga_r, vga_g, vga_b} <= FG_RGB;
            end else begin
                {vga_r, vga_g, vga_b} <= BG_RGB;
            end
            vga_hsync <= hs_d1;
            vga_vsync <= vs_d1;
            vga_de    <= de_d1;
        end
    end

endmodule
